// File: rtl/master_port.sv
// master_port: serial request master driving a bit-serial slave for single-word writes and reads.
// Parameters: N data width, ADN address width (ADN > N), TIMEOUT read watchdog limit in cycles.
// Ports: clk, rst (async, active-high); start/wr/addr/wdata request; busy, rdata, rdone, wdone, err status;
//        validIn/wren/Address/DataIn serial request lines to slave; ready/validOut/DataOut from slave.
// Config: define MASTER_TIMEOUT_EN to add the RWAIT watchdog that pulses err; otherwise err is tied 0.
module master_port #(
  parameter int N = 8,
  parameter int ADN = 12,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           wr,
  input  logic [ADN-1:0] addr,
  input  logic [N-1:0]   wdata,
  output logic           busy,
  output logic [N-1:0]   rdata,
  output logic           rdone,
  output logic           wdone,
  output logic           err,
  output logic           validIn,
  output logic           wren,
  output logic           Address,
  output logic           DataIn,
  input  logic           ready,
  input  logic           validOut,
  input  logic           DataOut
);
  localparam int CW = $clog2(ADN) + 1;
  typedef enum logic [2:0] {IDLE, REQ, ADDR, RWAIT, RCAP, WEND} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [ADN-1:0] a_sh;
  logic [ADN-1:0] d_sh;
  logic [N-2:0] cap;
  logic op_wr;
`ifdef MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tcnt;
`else
  assign err = 1'b0;
`endif
  // Write data is zero-extended to ADN bits so it shifts out alongside the address
  // and lands MSB-first in the last N ADDR cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      a_sh <= '0;
      d_sh <= '0;
      cap <= '0;
      op_wr <= 1'b0;
      busy <= 1'b0;
      rdata <= '0;
      rdone <= 1'b0;
      wdone <= 1'b0;
      validIn <= 1'b0;
      wren <= 1'b0;
      Address <= 1'b0;
      DataIn <= 1'b0;
`ifdef MASTER_TIMEOUT_EN
      tcnt <= '0;
      err <= 1'b0;
`endif
    end else begin
      rdone <= 1'b0;
      wdone <= 1'b0;
`ifdef MASTER_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: if (start && ready) begin
          state <= REQ;
          busy <= 1'b1;
          validIn <= 1'b1;
          wren <= wr;
          op_wr <= wr;
          a_sh <= addr;
          d_sh <= wr ? ADN'(wdata) : '0;
          cnt <= '0;
        end
        REQ, ADDR: begin
          state <= ADDR;
          cnt <= (state == REQ) ? '0 : cnt + 1'b1;
          Address <= a_sh[ADN-1];
          DataIn <= d_sh[ADN-1];
          a_sh <= a_sh << 1;
          d_sh <= d_sh << 1;
          if (state == ADDR && cnt == CW'(ADN - 1)) begin
            state <= op_wr ? WEND : RWAIT;
            cnt <= '0;
            validIn <= 1'b0;
            wren <= 1'b0;
            Address <= 1'b0;
            DataIn <= 1'b0;
`ifdef MASTER_TIMEOUT_EN
            tcnt <= '0;
`endif
          end
        end
        // cnt doubles as a flag so ready is ignored in the first WEND cycle.
        WEND: begin
          cnt <= CW'(1);
          if (cnt != '0 && ready) begin
            state <= IDLE;
            busy <= 1'b0;
            wdone <= 1'b1;
          end
        end
        // The first validOut cycle is a preamble; its DataOut is dropped.
        RWAIT: if (validOut) begin
          state <= RCAP;
          cnt <= '0;
        end
`ifdef MASTER_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
          err <= 1'b1;
        end else tcnt <= tcnt + 1'b1;
`endif
        RCAP: if (!validOut) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          cap <= (N-1)'({cap, DataOut});
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            rdata <= {cap, DataOut};
            rdone <= 1'b1;
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_master_port.sv
// tb_master_port: table-driven and randomized checks of master_port against a cycle-timing model and slave.
module tb_master_port;
  localparam int N = 8;
  localparam int ADN = 12;
  localparam int TO = 16;
  logic clk, rst, start, wr, busy, rdone, wdone, err;
  logic validIn, wren, Address, DataIn, ready, validOut, DataOut;
  logic [ADN-1:0] addr;
  logic [N-1:0] wdata, rdata;
  logic [N-1:0] smem [0:4095];
  logic [N-1:0] ref_mem [0:4095];
  logic [N-1:0] ref_rdata;
  int checks = 0;
  int errors = 0;
  typedef struct {
    bit w; logic [ADN-1:0] a; logic [N-1:0] d;
    int dly; int hold; int ab; bit bs;
    int exp_end; logic [N-1:0] exp_rd;
  } vec_t;
  vec_t tbl [8];
  master_port #(.N(N), .ADN(ADN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy), .rdata(rdata), .rdone(rdone), .wdone(wdone), .err(err),
    .validIn(validIn), .wren(wren), .Address(Address), .DataIn(DataIn),
    .ready(ready), .validOut(validOut), .DataOut(DataOut)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Cycle (counted from the REQ cycle = 0) at which the DUT is back in IDLE.
  function automatic int exp_end_f(input bit w, input int dly, input int hold, input int ab);
    if (w) return (hold > 1 ? ADN + 1 + hold : ADN + 2) + 1;
    if (dly < 0) return ADN + 1 + TO;
    if (ab >= 0) return ADN + 3 + dly + ab;
    return ADN + 2 + dly + N;
  endfunction
  task automatic run(input bit w, input logic [ADN-1:0] a, input logic [N-1:0] d, input int dly,
                     input int hold, input int ab, input bit bs, input int exp_end,
                     input logic [N-1:0] exp_rd, input string nm);
    logic [ADN-1:0] as, ds, de;
    logic [N-1:0] word;
    logic [4:0] req_v;
    int vc, st, bc, np, pc_w, pc_r, pc_e, pre, pc;
    bit sw;
    as = '0; ds = '0; word = '0; req_v = '0; sw = 0;
    vc = 0; st = 0; bc = 0; np = 0; pc_w = -1; pc_r = -1; pc_e = -1;
    pre = (w || dly < 0) ? -1 : ADN + 1 + dly;
    @(negedge clk);
    start = 1; wr = w; addr = a; wdata = d; ready = 1; validOut = 0; DataOut = 0;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < exp_end + 8; c++) begin
      if (c == 0) req_v = {validIn, wren, Address, DataIn, busy};
      if (c >= 1 && c <= ADN) begin
        as = {as[ADN-2:0], Address};
        ds = {ds[ADN-2:0], DataIn};
        if (c == 1) sw = wren;
      end
      if (c > ADN && (validIn || wren || Address || DataIn)) st++;
      vc += int'(validIn);
      bc += int'(busy);
      if (wdone) begin np++; if (pc_w < 0) pc_w = c; end
      if (rdone) begin np++; if (pc_r < 0) pc_r = c; end
      if (err) begin np++; if (pc_e < 0) pc_e = c; end
      if (c == ADN) begin
        if (sw) smem[as] = ds[N-1:0];
        word = smem[as];
      end
      start = bs && c == 5;
      if (bs && c == 5) begin wr = ~w; addr = ~a; end
      ready = !(w && c >= ADN + 1 && c < ADN + 1 + hold);
      validOut = pre >= 0 && c >= pre && c <= pre + N && !(ab >= 0 && c >= pre + 1 + ab);
      DataOut = (validOut && c > pre) ? word[N-1-(c-pre-1)] : 1'b0;
      @(negedge clk);
    end
    start = 0; ready = 1; validOut = 0; DataOut = 0;
    de = '0;
    for (int k = 0; k < ADN; k++) de[ADN-1-k] = (w && k >= ADN - N) ? d[N-1-(k-(ADN-N))] : 1'b0;
    pc = w ? pc_w : (dly < 0 ? pc_e : pc_r);
    check({nm, " req"}, req_v, {1'b1, w, 1'b0, 1'b0, 1'b1});
    check({nm, " addr"}, as, a);
    check({nm, " datain"}, ds, de);
    check({nm, " validin cnt"}, vc, ADN + 1);
    check({nm, " stray lines"}, st, 0);
    check({nm, " pulses"}, np, ab >= 0 ? 0 : 1);
    if (ab < 0) check({nm, " done cyc"}, pc, exp_end);
    check({nm, " busy cnt"}, bc, exp_end);
    check({nm, " rdata"}, rdata, exp_rd);
    if (w) ref_mem[a] = d;
    ref_rdata = exp_rd;
  endtask
  initial begin
    logic [ADN-1:0] ra;
    logic [N-1:0] rd;
    logic [31:0] acc;
    bit rw;
    int dl, hl;
    for (int i = 0; i < 4096; i++) begin
      smem[i] = N'(i * 37 + 5);
      ref_mem[i] = N'(i * 37 + 5);
    end
    tbl[0] = '{1, 12'h0A5, 8'h3C, 0, 0, -1, 0, 15, 8'h00};
    tbl[1] = '{0, 12'h0A5, 8'h00, 20, 0, -1, 0, 42, 8'h3C};
    tbl[2] = '{1, 12'hFFF, 8'hFF, 0, 3, -1, 0, 17, 8'h3C};
    tbl[3] = '{0, 12'hFFF, 8'h00, 0, 0, -1, 0, 22, 8'hFF};
    tbl[4] = '{1, 12'h000, 8'h00, 0, 1, -1, 1, 15, 8'hFF};
    tbl[5] = '{0, 12'h000, 8'h00, 1, 0, -1, 0, 23, 8'h00};
    tbl[6] = '{0, 12'h0A5, 8'h00, 2, 0, 3, 0, 20, 8'h00};
    tbl[7] = '{0, 12'h0A5, 8'h00, 3, 0, -1, 1, 25, 8'h3C};
    rst = 1; start = 0; wr = 0; addr = '0; wdata = '0; ready = 1; validOut = 0; DataOut = 0;
    ref_rdata = '0;
    @(negedge clk);
    check("reset outs", {busy, rdone, wdone, err, validIn, wren, Address, DataIn, rdata}, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++)
      run(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].dly, tbl[i].hold, tbl[i].ab, tbl[i].bs,
          tbl[i].exp_end, tbl[i].exp_rd, $sformatf("vec%0d", i));
    @(negedge clk);
    start = 1; wr = 1; addr = 12'h3C3; wdata = 8'h99; ready = 1;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    check("rst pre", validIn, 1);
    rst = 1;
    #1;
    check("rst async", {busy, rdone, wdone, err, validIn, wren, Address, DataIn, rdata}, 0);
    @(negedge clk);
    rst = 0;
    ref_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst idle", {busy, validIn}, 0);
    run(0, 12'h0A5, 8'h00, 4, 0, -1, 0, exp_end_f(0, 4, 0, -1), ref_mem[12'h0A5], "post rst");
    @(negedge clk);
    start = 1; wr = 1; addr = 12'h111; wdata = 8'h11; ready = 0;
    @(negedge clk);
    start = 0; ready = 1; acc = 0;
    repeat (4) begin
      acc = acc | {30'd0, busy, validIn};
      @(negedge clk);
    end
    check("start not ready", acc, 0);
    for (int i = 0; i < 10; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = ADN'($urandom);
      rd = N'($urandom);
      dl = int'($urandom_range(0, 6));
      hl = int'($urandom_range(0, 4));
      run(rw, ra, rd, dl, hl, -1, 1'($urandom_range(0, 1)), exp_end_f(rw, dl, hl, -1),
          rw ? ref_rdata : ref_mem[ra], $sformatf("rnd%0d", i));
    end
`ifdef MASTER_TIMEOUT_EN
    run(0, 12'h123, 8'h00, -1, 0, -1, 0, exp_end_f(0, -1, 0, -1), ref_rdata, "timeout");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
